fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 111 +++++++++++
 tb/tb_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit: one outstanding memory request feeding an in-order queue toward decode
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   req_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Issuing only with a free slot reserves room for the response, so push never overflows.
    assign imem_addr = pc;
    assign imem_req  = reset && (state == IDLE) && (count < FULL) && !flush;
    assign issue     = imem_req && imem_gnt;
    assign pc_en     = issue;

    assign push     = (state == WAIT) && imem_rvalid && !flush;
    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready && !flush;
    assign id_instr = instr_mem[rd_ptr];
    assign id_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= WAIT;
                        req_pc <= pc;
                    end
                end
                WAIT: begin
                    // A response arriving together with flush is simply dropped.
                    if (imem_rvalid)
                        state <= IDLE;
                    else if (flush)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (imem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with directed fetch, full, flush, wrap and reset scenarios
module tb_fetch_queue;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        auto_resp;
    logic        auto_rv = 1'b0;
    logic [31:0] auto_rd = '0;
    logic        man_rv;
    logic [31:0] man_rd;

    logic [31:0] pc_base;
    logic [31:0] cnt_at_set;
    logic [31:0] grant_cnt = '0;
    logic        s_grant = 1'b0;
    logic [31:0] s_addr = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pcen = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [15:0] rdy_pat;

    always #5 clk = ~clk;

    // PC stage model: advances by one per accepted request.
    assign pc = pc_base + (grant_cnt - cnt_at_set);

    fetch_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_en      (pc_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(auto_resp ? auto_rv : man_rv),
        .imem_rdata (auto_resp ? auto_rd : man_rd),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic [31:0] p);
        return {p, p ^ KEY};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_base    = v;
        cnt_at_set = grant_cnt;
    endtask

    task automatic wait_pc(input logic [31:0] target, input string name);
        for (int i = 0; i < 60 && pc != target; i++)
            step();
        chk(name, pc, target);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (exp_q.size() != 0 || id_valid); i++)
            step();
        n_cmp++;
        if (exp_q.size() != 0 || id_valid) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d entries outstanding id_valid %b expected 0 entries id_valid 0",
                     name, exp_q.size(), id_valid);
        end
    endtask

    // Memory responder: one-cycle read latency for every granted request.
    always @(posedge clk) begin
        #1;
        if (s_grant)
            grant_cnt = grant_cnt + 32'd1;
        auto_rv = s_grant;
        auto_rd = s_addr ^ KEY;
    end

    // Monitor: samples mid-cycle and checks every accepted head against the scoreboard.
    always @(negedge clk) begin
        s_grant = imem_req & imem_gnt;
        s_addr  = imem_addr;
        if (reset && pc_en)
            n_pcen++;
        if (reset && id_valid && id_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got pc %h instr %h expected no entry", id_pc, id_instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", id_pc, mon_e[63:32]);
                chk("pop_instr", id_instr, mon_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; imem_gnt = 1'b1; flush = 1'b0; id_ready = 1'b1;
        auto_resp = 1'b1; man_rv = 1'b0; man_rd = '0;
        pc_base = '0; cnt_at_set = '0;
        rdy_pat = 16'b1011_0010_0111_0100;

        // Reset holds outputs low even with a grant pending
        repeat (2) @(negedge clk);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_id_valid", id_valid, 1'b0);

        // Streaming pc 0..3 with minimum latency
        for (int p = 0; p < 4; p++)
            exp_q.push_back(ent(32'(p)));
        @(posedge clk); #2; reset = 1'b1;
        @(negedge clk);
        chk("first_req", imem_req, 1'b1);
        chk("first_pc_en", pc_en, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("lat_t1_id_valid", id_valid, 1'b0);
        @(negedge clk);
        chk("lat_t2_id_valid", id_valid, 1'b1);
        chk("lat_t2_id_pc", id_pc, 32'h0);
        wait_pc(32'h4, "stream_grants");
        imem_gnt = 1'b0;
        drain("stream");
        chk("stream_pc_en_pulses", 32'(n_pcen), 32'd4);

        // Fill to DEPTH with decode stalled, then one pop reopens issue
        id_ready = 1'b0; set_pc(32'h10); imem_gnt = 1'b1;
        for (int p = 16; p < 20; p++)
            exp_q.push_back(ent(32'(p)));
        wait_pc(32'h14, "full_grants");
        step(); step();
        @(negedge clk);
        chk("full_imem_req", imem_req, 1'b0);
        chk("full_pc_en", pc_en, 1'b0);
        chk("full_id_valid", id_valid, 1'b1);
        chk("full_head_pc", id_pc, 32'h10);
        step(); id_ready = 1'b1;
        step(); id_ready = 1'b0;
        exp_q.push_back(ent(32'h14));
        @(negedge clk);
        chk("full_reissue_req", imem_req, 1'b1);
        chk("full_reissue_addr", imem_addr, 32'h14);
        step(); imem_gnt = 1'b0;
        step(); id_ready = 1'b1;
        drain("full");

        // Flush while waiting, response arrives later in DRAIN
        auto_resp = 1'b0; man_rv = 1'b0; set_pc(32'h20); imem_gnt = 1'b1;
        @(negedge clk);
        chk("fw_grant", pc_en, 1'b1);
        step(); imem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fw_req_in_flush", imem_req, 1'b0);
        step(); flush = 1'b0;
        @(negedge clk);
        chk("fw_drain_req", imem_req, 1'b0);
        step(); man_rv = 1'b1; man_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("fw_drain_rv_req", imem_req, 1'b0);
        chk("fw_drain_id_valid", id_valid, 1'b0);
        step(); man_rv = 1'b0;
        @(negedge clk);
        chk("fw_idle_req", imem_req, 1'b1);
        chk("fw_idle_id_valid", id_valid, 1'b0);

        // Flush and response in the same WAIT cycle
        step(); set_pc(32'h30); imem_gnt = 1'b1;
        @(negedge clk);
        chk("sim_grant", pc_en, 1'b1);
        step(); imem_gnt = 1'b0; flush = 1'b1; man_rv = 1'b1; man_rd = 32'h30 ^ KEY;
        @(negedge clk);
        chk("sim_req_in_flush", imem_req, 1'b0);
        step(); flush = 1'b0; man_rv = 1'b0;
        @(negedge clk);
        chk("sim_idle_req", imem_req, 1'b1);
        chk("sim_id_valid", id_valid, 1'b0);

        // Flush discards queued entries
        step(); auto_resp = 1'b1; id_ready = 1'b0; set_pc(32'h40); imem_gnt = 1'b1;
        wait_pc(32'h42, "fq_grants");
        imem_gnt = 1'b0;
        step();
        @(negedge clk);
        chk("fq_id_valid", id_valid, 1'b1);
        chk("fq_head_pc", id_pc, 32'h40);
        step(); flush = 1'b1;
        @(negedge clk);
        chk("fq_req_in_flush", imem_req, 1'b0);
        step(); flush = 1'b0;
        @(negedge clk);
        chk("fq_id_valid_after", id_valid, 1'b0);
        chk("fq_req_after", imem_req, 1'b1);

        // Ten entries through a four-deep queue with irregular decode stalls
        step(); set_pc(32'h50); imem_gnt = 1'b1;
        for (int p = 32'h50; p < 32'h5A; p++)
            exp_q.push_back(ent(32'(p)));
        for (int i = 0; i < 80 && pc != 32'h5A; i++) begin
            id_ready = rdy_pat[i % 16];
            step();
        end
        chk("wrap_grants", pc, 32'h5A);
        imem_gnt = 1'b0; id_ready = 1'b1;
        drain("wrap");

        // Reset while a response is outstanding
        auto_resp = 1'b0; man_rv = 1'b0; set_pc(32'h60); imem_gnt = 1'b1;
        @(negedge clk);
        chk("rw_grant", pc_en, 1'b1);
        step(); reset = 1'b0;
        @(negedge clk);
        chk("rw_rst_req", imem_req, 1'b0);
        chk("rw_rst_pc_en", pc_en, 1'b0);
        chk("rw_rst_id_valid", id_valid, 1'b0);
        step(); reset = 1'b1; imem_gnt = 1'b0; man_rv = 1'b1; man_rd = 32'h60 ^ KEY;
        @(negedge clk);
        chk("rw_req_after", imem_req, 1'b1);
        chk("rw_addr_after", imem_addr, 32'h61);
        chk("rw_id_valid_rv", id_valid, 1'b0);
        step(); man_rv = 1'b0;
        @(negedge clk);
        chk("rw_id_valid_next", id_valid, 1'b0);
        step(); auto_resp = 1'b1; imem_gnt = 1'b1;
        exp_q.push_back(ent(32'h61));
        step(); imem_gnt = 1'b0;
        drain("rw");

        step(); step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
